// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state enum, requester limit, and default stall timeout.
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  localparam int ARB_MAX_REQ     = 8;
  localparam int ARB_DEF_TIMEOUT = 1_000_000;
  localparam int ARB_BYTE_W      = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first request searching up from ptr+1.
// Returns the winner as one-hot plus its index; reusable for other shared sinks.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int off = 1; off <= N; off++) begin
      j = (int'(ptr_i) + off) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the UART transmit sink.
// Optional stall timeout on a locked requester: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = ARB_DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ARB_BYTE_W*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [ARB_BYTE_W-1:0]         o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [ARB_BYTE_W-1:0]   data_q, data_d;
  logic                    vld_q, vld_d;
  logic                    to_q, to_d;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IW-1:0]           pick_idx;
  logic                    locked;
  logic                    can_take;
  logic                    accept;
  logic                    stall_to;

  uart_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign locked   = (state_q == ARB_LOCKED);
  assign can_take = !vld_q || i_tx_ready;
  assign accept   = locked && i_req_valid[idx_q] && can_take;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the edge where the idle count would reach the limit
  assign stall_to = locked && !i_req_valid[idx_q] &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!locked || accept)
      cnt_d = '0;
    else if (!i_req_valid[idx_q])
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign stall_to = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    to_d    = 1'b0;

    if (accept) begin
      data_d = i_req_data[int'(idx_q)*ARB_BYTE_W +: ARB_BYTE_W];
      vld_d  = 1'b1;
    end else if (i_tx_ready) begin
      vld_d  = 1'b0;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (|i_req_valid) begin
          grant_d = pick_gnt;
          idx_d   = pick_idx;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if ((accept && i_req_last[idx_q]) || stall_to) begin
          ptr_d   = idx_q;
          grant_d = '0;
          state_d = ARB_IDLE;
          to_d    = stall_to;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      data_q  <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  assign o_req_ready = (locked && can_take) ? grant_q : '0;
  assign o_tx_data   = data_q;
  assign o_tx_valid  = vld_q;
  assign o_grant     = grant_q;
  assign o_busy      = locked;
  assign o_timeout   = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand sequences.
// Covers arbitration order, back-pressure, mid-packet reset and timeout.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_valid;
  logic [3:0]  i_req_last;
  logic [3:0]  o_req_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [3:0]  o_grant;
  logic        o_busy;
  logic        o_timeout;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req_data  (i_req_data),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;
    logic        rdy;
    logic [3:0]  e_gnt;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_busy;
    logic [3:0]  e_rdy;
  } vec_t;

  vec_t tv[$];
  logic [7:0] sb[$];
  logic       mon_en = 1'b0;

  always @(posedge clk)
    if (mon_en && reset_n && o_tx_valid && i_tx_ready)
      sb.push_back(o_tx_data);

  function automatic vec_t mk(
    logic [3:0] vld, logic [3:0] lst, logic [31:0] dat, logic rdy,
    logic [3:0] eg, logic ev, logic [7:0] ed, logic eb, logic [3:0] er);
    vec_t v;
    v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
    v.e_gnt = eg; v.e_vld = ev; v.e_dat = ed; v.e_busy = eb; v.e_rdy = er;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] v, logic [3:0] l, logic [31:0] d,
                       logic r);
    i_req_valid = v;
    i_req_last  = l;
    i_req_data  = d;
    i_tx_ready  = r;
  endtask

  logic [7:0] exp_bytes[11];
  int         hold_bad;
  int         to_seen;

  initial begin
    exp_bytes = '{8'h53, 8'h55, 8'h44, 8'hA0, 8'hA1, 8'hB0, 8'hB1,
                  8'hC2, 8'hD0, 8'hD1, 8'hD2};

    // requester 2 packet
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        1, 4'h0, 0, 8'h00, 0, 4'h0));
    tv.push_back(mk(4'h4, 4'h0, 32'h00530000, 1, 4'h0, 0, 8'h00, 0, 4'h0));
    tv.push_back(mk(4'h4, 4'h0, 32'h00530000, 1, 4'h4, 0, 8'h00, 1, 4'h4));
    tv.push_back(mk(4'h4, 4'h0, 32'h00550000, 1, 4'h4, 1, 8'h53, 1, 4'h4));
    tv.push_back(mk(4'h4, 4'h4, 32'h00440000, 1, 4'h4, 1, 8'h55, 1, 4'h4));
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        1, 4'h0, 1, 8'h44, 0, 4'h0));
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        1, 4'h0, 0, 8'h44, 0, 4'h0));
    // requesters 0 and 1 together, then round starting at 2
    tv.push_back(mk(4'h3, 4'h0, 32'h0000B0A0, 1, 4'h0, 0, 8'h44, 0, 4'h0));
    tv.push_back(mk(4'h3, 4'h0, 32'h0000B0A0, 1, 4'h1, 0, 8'h44, 1, 4'h1));
    tv.push_back(mk(4'h3, 4'h1, 32'h0000B0A1, 1, 4'h1, 1, 8'hA0, 1, 4'h1));
    tv.push_back(mk(4'h2, 4'h0, 32'h0000B000, 1, 4'h0, 1, 8'hA1, 0, 4'h0));
    tv.push_back(mk(4'h2, 4'h0, 32'h0000B000, 1, 4'h2, 0, 8'hA1, 1, 4'h2));
    tv.push_back(mk(4'h2, 4'h2, 32'h0000B100, 1, 4'h2, 1, 8'hB0, 1, 4'h2));
    tv.push_back(mk(4'hF, 4'h0, 32'h0,        1, 4'h0, 1, 8'hB1, 0, 4'h0));
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        1, 4'h4, 0, 8'hB1, 1, 4'h4));
    tv.push_back(mk(4'h4, 4'h4, 32'h00C20000, 1, 4'h4, 0, 8'hB1, 1, 4'h4));
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        1, 4'h0, 1, 8'hC2, 0, 4'h0));
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        1, 4'h0, 0, 8'hC2, 0, 4'h0));
    // back-pressure: tx_ready 1,0,0,1
    tv.push_back(mk(4'h8, 4'h0, 32'hD0000000, 1, 4'h0, 0, 8'hC2, 0, 4'h0));
    tv.push_back(mk(4'h8, 4'h0, 32'hD0000000, 1, 4'h8, 0, 8'hC2, 1, 4'h8));
    tv.push_back(mk(4'h8, 4'h0, 32'hD1000000, 0, 4'h8, 1, 8'hD0, 1, 4'h0));
    tv.push_back(mk(4'h8, 4'h0, 32'hD1000000, 0, 4'h8, 1, 8'hD0, 1, 4'h0));
    tv.push_back(mk(4'h8, 4'h0, 32'hD1000000, 1, 4'h8, 1, 8'hD0, 1, 4'h8));
    tv.push_back(mk(4'h8, 4'h8, 32'hD2000000, 1, 4'h8, 1, 8'hD1, 1, 4'h8));
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        0, 4'h0, 1, 8'hD2, 0, 4'h0));
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        1, 4'h0, 1, 8'hD2, 0, 4'h0));
    tv.push_back(mk(4'h0, 4'h0, 32'h0,        1, 4'h0, 0, 8'hD2, 0, 4'h0));

    reset_n = 1'b0;
    drive(4'h0, 4'h0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].vld, tv[i].lst, tv[i].dat, tv[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d.grant", i), 32'(o_grant), 32'(tv[i].e_gnt));
      chk($sformatf("v%0d.tx_valid", i), 32'(o_tx_valid), 32'(tv[i].e_vld));
      chk($sformatf("v%0d.tx_data", i), 32'(o_tx_data), 32'(tv[i].e_dat));
      chk($sformatf("v%0d.busy", i), 32'(o_busy), 32'(tv[i].e_busy));
      chk($sformatf("v%0d.req_ready", i), 32'(o_req_ready), 32'(tv[i].e_rdy));
      chk($sformatf("v%0d.timeout", i), 32'(o_timeout), 32'd0);
      tick();
    end

    mon_en = 1'b0;
    chk("stream.count", 32'(sb.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < sb.size())
        chk($sformatf("stream.byte%0d", i), 32'(sb[i]), 32'(exp_bytes[i]));

    // leave ptr at 0, then reset in the middle of a requester-1 packet
    drive(4'h1, 4'h1, 32'h000000F0, 1'b1);
    tick();
    chk("r0.grant", 32'(o_grant), 32'h1);
    tick();
    chk("r0.data", 32'(o_tx_data), 32'hF0);
    drive(4'h2, 4'h0, 32'h0000E000, 1'b1);
    tick();
    chk("r1.grant", 32'(o_grant), 32'h2);
    tick();
    chk("r1.byte1_valid", 32'(o_tx_valid), 32'h1);
    chk("r1.byte1_data", 32'(o_tx_data), 32'hE0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst.tx_valid", 32'(o_tx_valid), 32'h0);
    chk("rst.grant", 32'(o_grant), 32'h0);
    chk("rst.busy", 32'(o_busy), 32'h0);
    chk("rst.tx_data", 32'(o_tx_data), 32'h0);
    drive(4'h3, 4'h0, 32'h0, 1'b1);
    tick();
    chk("rst.next_grant", 32'(o_grant), 32'h1);
    drive(4'h1, 4'h1, 32'h000000F1, 1'b1);
    tick();
    chk("rst.close_busy", 32'(o_busy), 32'h0);
    drive(4'h0, 4'h0, 32'h0, 1'b1);
    tick();
    tick();

    // requester 1 sends one byte without last, requester 3 waits
    drive(4'h2, 4'h0, 32'h00007700, 1'b1);
    tick();
    chk("to.grant1", 32'(o_grant), 32'h2);
    tick();
    chk("to.byte", 32'(o_tx_data), 32'h77);
    drive(4'h8, 4'h0, 32'h33000000, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    hold_bad = 0;
    for (int c = 1; c < 16; c++) begin
      tick();
      if (o_timeout !== 1'b0 || o_grant !== 4'h2) hold_bad++;
    end
    chk("to.early", 32'(hold_bad), 32'd0);
    tick();
    chk("to.pulse", 32'(o_timeout), 32'h1);
    chk("to.released", 32'(o_grant), 32'h0);
    tick();
    chk("to.pulse_end", 32'(o_timeout), 32'h0);
    chk("to.grant3", 32'(o_grant), 32'h8);
`else
    hold_bad = 0;
    to_seen  = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (o_grant !== 4'h2) hold_bad++;
      if (o_timeout !== 1'b0) to_seen++;
    end
    chk("hold.grant", 32'(hold_bad), 32'd0);
    chk("hold.timeout", 32'(to_seen), 32'd0);
    chk("hold.busy", 32'(o_busy), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
